instr_fetch_ctrl: RTL

Fetch sequencer that owns the program counter and drives the combinational instruction memory (word-addressed internally as `PC>>2`, `IR_MEM_SIZE` words). Each cycle it presents a byte address, captures the returned word with its PC into a 2-entry buffer, and hands instructions to decode over a valid/ready handshake. It also handles jump/branch redirects with buffer flush and traps illegal fetch addresses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 75 +++++++
 rtl/instr_fetch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned STALL_W    = 16;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A fetch address is usable only when word aligned and inside the memory.
    function automatic logic pcIsLegal(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; entry 0 is always the head.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem0;
    fetch_entry_t r_mem1;
    logic [1:0]   r_count;

    fetch_entry_t w_mem0Next;
    fetch_entry_t w_mem1Next;
    logic [1:0]   w_countNext;

    // Next-state of the shift-style FIFO; flush wins over any push or pop.
    always_comb begin
        w_mem0Next  = r_mem0;
        w_mem1Next  = r_mem1;
        w_countNext = r_count;
        if (i_flush) begin
            w_countNext = 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        w_mem0Next = i_data;
                    end else begin
                        w_mem1Next = i_data;
                    end
                    w_countNext = r_count + 2'd1;
                end
                2'b01: begin
                    w_mem0Next  = r_mem1;
                    w_countNext = r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        w_mem0Next = i_data;
                    end else begin
                        w_mem0Next = r_mem1;
                        w_mem1Next = i_data;
                    end
                end
                default: begin
                    w_countNext = r_count;
                end
            endcase
        end
    end

    // Storage registers; cleared on reset so the head never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            r_mem0  <= w_mem0Next;
            r_mem1  <= w_mem1Next;
            r_count <= w_countNext;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the instruction memory, buffers words
// for decode and handles redirects and illegal fetch addresses.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned IR_MEM_SIZE = 1000,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [31:0]         imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4,
    output logic                fault,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam logic [31:0] PC_LIMIT = 32'(WORD_BYTES * IR_MEM_SIZE);

    fetch_state_e       r_state;
    logic [31:0]        r_pc;
    logic [STALL_W-1:0] r_stallCnt;

    fetch_state_e       w_stateNext;
    logic [31:0]        w_pcNext;
    logic               w_push;
    logic               w_flush;
    logic               w_stallInc;
    logic               w_pop;
    logic               w_pushOk;
    logic [1:0]         w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_pushData;

    assign if_valid   = (w_count != 2'd0);
    assign w_pop      = if_valid && if_ready;
    assign w_pushOk   = (w_count != 2'd2) || w_pop;
    assign w_pushData = '{pc: r_pc, instr: imem_rdata};

    // Next state, next PC and buffer controls; a redirect overrides everything.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        w_stallInc  = 1'b0;
        if (redirect_valid) begin
            w_flush     = 1'b1;
            w_pcNext    = redirect_pc;
            w_stateNext = RUN;
        end else if (r_state == RUN) begin
            w_stallInc = !w_pushOk;
            if (!pcIsLegal(r_pc, PC_LIMIT)) begin
                w_stateNext = FAULT;
            end else if (w_pushOk) begin
                w_push   = 1'b1;
                w_pcNext = r_pc + 32'(WORD_BYTES);
            end
        end
    end

    // State and program counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

    // Saturating count of cycles lost to a full, unread buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (w_stallInc && (r_stallCnt != {STALL_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    fetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_pushData),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_addr   = r_pc;
    assign if_instr    = w_head.instr;
    assign if_pc       = w_head.pc;
    assign if_pc_plus4 = w_head.pc + 32'(WORD_BYTES);
    assign fault       = (r_state == FAULT);
    assign stall_cnt   = r_stallCnt;

endmodule
